top: RTL and testbench
======================

TOP -- requirements
Module: top

Interface
REQ-001 Clk  in  1  single system clock; all state updates on its rising edge.
REQ-002 Reset  in  1  asynchronous, active-low reset; Reset=0 forces reset state immediately.
REQ-003 InputKey  in  1  serial unlock-key bit, sampled each Clk.
REQ-004 ValidCmd  in  1  command strobe, active-high.
REQ-005 RW  in  1  command type: 1=write, 0=read.
REQ-006 ConfigDiv  in  1  write target: 1=divider register, 0=memory.
REQ-007 Addr  in  8  memory address; only Addr[3:0] used.
REQ-008 Din  in  32  write data.
REQ-009 InA, InB  in  8 each  ALU operands.
REQ-010 Sel  in  4  ALU opcode.
REQ-011 Unlocked  out  1  high once key accepted.
REQ-012 AluOut  out  16  registered ALU result.
REQ-013 Zero  out  1  registered, AluOut==0.
REQ-014 Dout  out  32  registered read data.
REQ-015 RdValid  out  1  one-cycle pulse with each read.
REQ-016 ClkOut  out  1  divided clock.

Function
REQ-017 Key FSM states: S0, S1, S2, S3, OPEN; key sequence 0,1,0,1 on consecutive clocks.
REQ-018 Transitions:
- S0: 0->S1, else stay.
- S1: 1->S2, 0->S1.
- S2: 0->S3, 1->S0.
- S3: 1->OPEN, 0->S1.
- OPEN is absorbing until reset.
REQ-019 Unlocked=1 iff state==OPEN; it rises on the edge sampling the final 1.
REQ-020 Command accepted on a Clk edge iff Unlocked=1 and ValidCmd=1; commands while locked are ignored with no state change.
REQ-021 Write (RW=1):
- ConfigDiv=1: DivVal<=Din; memory unchanged.
- ConfigDiv=0: mem[Addr[3:0]]<=Din.
- Memory is 16x32.
REQ-022 Read (RW=0): Dout<=mem[Addr[3:0]] and RdValid=1 for that cycle, latency one clock; reads ignore ConfigDiv; Dout holds its value otherwise.
REQ-023 Write and read to the same address on consecutive accepted cycles: the read returns the newly written data.
REQ-024 ALU on every accepted command (read or write), AluOut<=f(InA,InB,Sel), operands zero-extended to 16 bits:
- 0: A+B
- 1: A-B (16-bit two's complement wrap)
- 2: A*B
- 3: A&B
- 4: A|B
- 5: A^B
- 6: ~A (upper byte 0)
- 7: A<<B[2:0]
- 8: A>>B[2:0]
- 9: (A>B)?1:0
- 10: (A==B)?1:0
- 11-15: 0
REQ-025 AluOut holds its value when no command is accepted; Zero updates together with AluOut.
REQ-026 Clock divider:
- 32-bit counter Cnt.
- DivVal=0: ClkOut held 0, Cnt held 0.
- DivVal=N≥1: Cnt counts 0..N-1; on reaching N-1, Cnt<=0 and ClkOut toggles; period 2N Clk cycles.
REQ-027 Writing DivVal resets Cnt to 0 on the same edge; ClkOut keeps its current level.
REQ-028 The divider runs regardless of lock state.

Reset
REQ-029 Reset=0 asynchronously sets:
- FSM=S0, Unlocked=0, AluOut=0, Zero=1, Dout=0, RdValid=0
- DivVal=1, Cnt=0, ClkOut=0
- all memory words = 0
REQ-030 Reset asserted mid-operation aborts any command; the first accepted command after release still requires a new full key sequence.

Verification
REQ-031 Reset release, InputKey 1,0,1,0,1 on consecutive clocks -> Unlocked rises on the edge sampling the last 1.
REQ-032 Key 0,1,1,0,1,0,1 -> stays locked after the third bit; unlocks after the final 1.
REQ-033 Locked, ValidCmd=1, RW=1, ConfigDiv=0, Addr=1, Din=0x2 -> mem[1] unchanged; after unlock, a read of Addr 1 returns Dout=0.
REQ-034 Unlocked, write Din=0xA5 to Addr 0x01 (ConfigDiv=0), next cycle read Addr 0x01 -> Dout=0x000000A5, RdValid one-cycle pulse.
REQ-035 Unlocked, InA=0x06, InB=0x06 with ValidCmd=1:
- Sel=0 -> AluOut=0x000C
- Sel=1 -> AluOut=0, Zero=1
- Sel=2 -> AluOut=0x0024
- InA=0x01, InB=0x05, Sel=1 -> AluOut=0xFFFC
REQ-036 Unlocked, write ConfigDiv=1, Din=2 -> ClkOut toggles every 2 Clk cycles (period 4 Clk); Din=0 -> ClkOut stays 0.

Source files
------------

// File: rtl/top_if.sv
// Bundles the command, key, ALU and status signals of the lockable
// memory/ALU/divider block so that the design and its bench connect
// through a single port.
interface top_if;
    logic        InputKey;
    logic        ValidCmd;
    logic        RW;
    logic        ConfigDiv;
    logic [7:0]  Addr;
    logic [31:0] Din;
    logic [7:0]  InA;
    logic [7:0]  InB;
    logic [3:0]  Sel;
    logic        Unlocked;
    logic [15:0] AluOut;
    logic        Zero;
    logic [31:0] Dout;
    logic        RdValid;
    logic        ClkOut;

    // Driver side: issues key bits, commands and operands.
    modport master (
        output InputKey, ValidCmd, RW, ConfigDiv, Addr, Din, InA, InB, Sel,
        input  Unlocked, AluOut, Zero, Dout, RdValid, ClkOut
    );

    // Design side: consumes commands and presents registered results.
    modport slave (
        input  InputKey, ValidCmd, RW, ConfigDiv, Addr, Din, InA, InB, Sel,
        output Unlocked, AluOut, Zero, Dout, RdValid, ClkOut
    );
endinterface

// File: rtl/top.sv
// Key-locked command block: a serial 0,1,0,1 key opens the unit, after
// which commands read/write a 16x32 memory or the clock-divider register
// and drive a registered 8-bit ALU. The clock divider runs independently
// of the lock state.
module top #(
    parameter int DATA_W = 32
) (
    input  logic Clk,
    input  logic Reset,
    top_if.slave bus
);

    localparam logic [2:0] S0   = 3'd0;
    localparam logic [2:0] S1   = 3'd1;
    localparam logic [2:0] S2   = 3'd2;
    localparam logic [2:0] S3   = 3'd3;
    localparam logic [2:0] OPEN = 3'd4;

    logic [2:0]        state;
    logic [2:0]        state_nxt;
    logic              unlocked;
    logic              accept;
    logic              wr_div;
    logic              wr_mem;
    logic              rd_cmd;
    logic [3:0]        idx;
    logic [15:0]       alu_res;
    logic [15:0]       alu_q;
    logic              zero_q;
    logic [DATA_W-1:0] dout_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] div_val;
    logic [DATA_W-1:0] cnt;
    logic              clk_out_q;
    logic [DATA_W-1:0] mem [16];
    logic              unused_addr;

    // Eight-bit operands are zero-extended to 16 bits so that subtraction
    // wraps in 16-bit two's complement and the product never overflows.
    function automatic logic [15:0] alu_f(input logic [7:0] a,
                                          input logic [7:0] b,
                                          input logic [3:0] sel);
        logic [15:0] ea;
        logic [15:0] eb;
        logic [15:0] r;
        ea = {8'h00, a};
        eb = {8'h00, b};
        r  = 16'h0000;
        case (sel)
            4'd0:    r = ea + eb;
            4'd1:    r = ea - eb;
            4'd2:    r = ea * eb;
            4'd3:    r = ea & eb;
            4'd4:    r = ea | eb;
            4'd5:    r = ea ^ eb;
            4'd6:    r = {8'h00, ~a};
            4'd7:    r = ea << b[2:0];
            4'd8:    r = ea >> b[2:0];
            4'd9:    r = {15'd0, (a > b)};
            4'd10:   r = {15'd0, (a == b)};
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    assign unlocked    = (state == OPEN);
    assign accept      = unlocked & bus.ValidCmd;
    assign wr_div      = accept & bus.RW & bus.ConfigDiv;
    assign wr_mem      = accept & bus.RW & ~bus.ConfigDiv;
    assign rd_cmd      = accept & ~bus.RW;
    assign idx         = bus.Addr[3:0];
    assign alu_res     = alu_f(bus.InA, bus.InB, bus.Sel);
    assign unused_addr = ^bus.Addr[7:4];

    // Key recogniser: next state from the current state and the key bit.
    always_comb begin
        state_nxt = state;
        case (state)
            S0:      state_nxt = bus.InputKey ? S0   : S1;
            S1:      state_nxt = bus.InputKey ? S2   : S1;
            S2:      state_nxt = bus.InputKey ? S0   : S3;
            S3:      state_nxt = bus.InputKey ? OPEN : S1;
            OPEN:    state_nxt = OPEN;
            default: state_nxt = S0;
        endcase
    end

    // Key recogniser state register; OPEN is left only through reset.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state <= S0;
        end else begin
            state <= state_nxt;
        end
    end

    // Memory array: written only by accepted memory writes.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 16; i++) begin
                mem[i] <= '0;
            end
        end else if (wr_mem) begin
            mem[idx] <= bus.Din;
        end
    end

    // Read port: one-clock latency, data held between reads, valid pulses.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            dout_q     <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_cmd;
            if (rd_cmd) begin
                dout_q <= mem[idx];
            end
        end
    end

    // ALU result and zero flag update together on every accepted command.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            alu_q  <= 16'h0000;
            zero_q <= 1'b1;
        end else if (accept) begin
            alu_q  <= alu_res;
            zero_q <= (alu_res == 16'h0000);
        end
    end

    // Divider register: a new value restarts the count but keeps ClkOut.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            div_val <= DATA_W'(1);
        end else if (wr_div) begin
            div_val <= bus.Din;
        end
    end

    // Divider counter: toggles ClkOut every div_val cycles, idles at 0 when off.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            cnt       <= '0;
            clk_out_q <= 1'b0;
        end else if (wr_div) begin
            cnt       <= '0;
        end else if (div_val == '0) begin
            cnt       <= '0;
            clk_out_q <= 1'b0;
        end else if (cnt == div_val - DATA_W'(1)) begin
            cnt       <= '0;
            clk_out_q <= ~clk_out_q;
        end else begin
            cnt       <= cnt + DATA_W'(1);
        end
    end

    assign bus.Unlocked = unlocked;
    assign bus.AluOut   = alu_q;
    assign bus.Zero     = zero_q;
    assign bus.Dout     = dout_q;
    assign bus.RdValid  = rd_valid_q;
    assign bus.ClkOut   = clk_out_q;

endmodule

// File: tb/tb_top.sv
// Scoreboard bench for the key-locked memory/ALU/divider block. Stimulus
// pushes hand-computed expectations tagged with the cycle they apply to;
// a negedge monitor pops and compares them.
module tb_top;

    localparam int K_RST  = 0;
    localparam int K_ALU  = 1;
    localparam int K_READ = 2;
    localparam int K_NORD = 3;
    localparam int K_UNLK = 4;
    localparam int K_CLK  = 5;

    typedef struct {
        int          due;
        int          kind;
        logic [63:0] exp;
        string       name;
    } exp_t;

    logic Clk;
    logic Reset;
    int   cyc;
    int   total_cnt;
    int   pass_cnt;
    exp_t sb[$];
    exp_t cur;
    logic [63:0] act;
    bit   saw_read;

    top_if bus ();

    top dut (
        .Clk   (Clk),
        .Reset (Reset),
        .bus   (bus.slave)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    // Monitor: compare every expectation due in this cycle.
    always @(negedge Clk) begin
        saw_read = 1'b0;
        while (sb.size() != 0 && sb[0].due <= cyc) begin
            cur = sb.pop_front();
            case (cur.kind)
                K_RST:  act = {12'h0, bus.Unlocked, bus.AluOut, bus.Zero,
                               bus.Dout, bus.RdValid, bus.ClkOut};
                K_ALU:  act = {47'h0, bus.Zero, bus.AluOut};
                K_READ: act = {31'h0, bus.RdValid, bus.Dout};
                K_NORD: act = {63'h0, bus.RdValid};
                K_UNLK: act = {63'h0, bus.Unlocked};
                default: act = {63'h0, bus.ClkOut};
            endcase
            if (cur.kind == K_READ) saw_read = 1'b1;
            total_cnt++;
            if (cur.due < cyc)
                $display("FAIL %s: check slot missed (due %0d, now %0d)", cur.name, cur.due, cyc);
            else if (act === cur.exp)
                pass_cnt++;
            else
                $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", cur.name, act, cur.exp, cyc);
        end
        if (bus.RdValid === 1'b1 && !saw_read) begin
            total_cnt++;
            $display("FAIL spurious_rdvalid: got 1 expected 0 (cycle %0d)", cyc);
        end
    end

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic push(input int kind, input logic [63:0] exp, input string name);
        sb.push_back('{cyc + 1, kind, exp, name});
    endtask

    task automatic push_now(input int kind, input logic [63:0] exp, input string name);
        sb.push_back('{cyc, kind, exp, name});
    endtask

    task automatic key(input logic b, input logic exp_unl, input string name);
        bus.InputKey = b;
        bus.ValidCmd = 1'b0;
        push(K_UNLK, {63'h0, exp_unl}, name);
        step();
    endtask

    task automatic cmd(input logic rw, input logic cfg, input logic [7:0] addr,
                       input logic [31:0] din, input logic [7:0] a,
                       input logic [7:0] b, input logic [3:0] sel);
        bus.ValidCmd  = 1'b1;
        bus.RW        = rw;
        bus.ConfigDiv = cfg;
        bus.Addr      = addr;
        bus.Din       = din;
        bus.InA       = a;
        bus.InB       = b;
        bus.Sel       = sel;
        step();
        bus.ValidCmd  = 1'b0;
    endtask

    task automatic alu(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel,
                       input logic [15:0] exp, input string name);
        push(K_ALU, {47'h0, (exp == 16'h0), exp}, name);
        cmd(1'b1, 1'b0, 8'h0E, 32'h0, a, b, sel);
    endtask

    task automatic idle_clk(input logic exp, input string name);
        push(K_CLK, {63'h0, exp}, name);
        step();
    endtask

    localparam logic [63:0] RST_EXP = {12'h0, 1'b0, 16'h0000, 1'b1, 32'h0, 1'b0, 1'b0};

    initial begin
        total_cnt = 0;
        pass_cnt  = 0;
        Reset         = 1'b0;
        bus.InputKey  = 1'b1;
        bus.ValidCmd  = 1'b0;
        bus.RW        = 1'b0;
        bus.ConfigDiv = 1'b0;
        bus.Addr      = 8'h00;
        bus.Din       = 32'h0;
        bus.InA       = 8'h00;
        bus.InB       = 8'h00;
        bus.Sel       = 4'h0;

        // Reset state.
        step();
        push_now(K_RST, RST_EXP, "reset_state");
        step();
        Reset = 1'b1;

        // Commands while locked are ignored.
        push(K_ALU, {47'h0, 1'b1, 16'h0000}, "locked_alu_hold");
        push(K_UNLK, 64'h0, "locked_write_unl");
        cmd(1'b1, 1'b0, 8'h01, 32'h2, 8'h03, 8'h04, 4'h0);
        push(K_NORD, 64'h0, "locked_read_no_valid");
        cmd(1'b0, 1'b0, 8'h01, 32'h0, 8'h03, 8'h04, 4'h0);

        // Key 1,0,1,0,1.
        key(1'b1, 1'b0, "key_a1");
        key(1'b0, 1'b0, "key_a2");
        key(1'b1, 1'b0, "key_a3");
        key(1'b0, 1'b0, "key_a4");
        key(1'b1, 1'b1, "key_a5_open");

        // Locked write did not land; read also runs the ALU.
        push(K_READ, {31'h0, 1'b1, 32'h0}, "read_after_locked_write");
        push(K_ALU, {47'h0, 1'b0, 16'h000C}, "alu_add_6_6");
        cmd(1'b0, 1'b0, 8'h01, 32'h0, 8'h06, 8'h06, 4'h0);
        push(K_NORD, 64'h0, "rdvalid_one_pulse_a");
        push(K_ALU, {47'h0, 1'b0, 16'h000C}, "alu_hold_idle");
        step();

        // Write then read same address on consecutive cycles.
        push(K_ALU, {47'h0, 1'b1, 16'h0000}, "alu_sub_6_6_zero");
        cmd(1'b1, 1'b0, 8'h01, 32'hA5, 8'h06, 8'h06, 4'h1);
        push(K_READ, {31'h0, 1'b1, 32'h0000_00A5}, "read_back_A5");
        push(K_ALU, {47'h0, 1'b0, 16'h0024}, "alu_mul_6_6");
        cmd(1'b0, 1'b0, 8'h01, 32'h0, 8'h06, 8'h06, 4'h2);
        push(K_NORD, 64'h0, "rdvalid_one_pulse_b");
        step();

        // ALU opcodes.
        alu(8'h01, 8'h05, 4'd1,  16'hFFFC, "alu_sub_wrap");
        alu(8'hF0, 8'h3C, 4'd3,  16'h0030, "alu_and");
        alu(8'hF0, 8'h3C, 4'd4,  16'h00FC, "alu_or");
        alu(8'hF0, 8'h3C, 4'd5,  16'h00CC, "alu_xor");
        alu(8'hF0, 8'h3C, 4'd6,  16'h000F, "alu_not");
        alu(8'h81, 8'h0B, 4'd7,  16'h0408, "alu_shl");
        alu(8'h81, 8'h0B, 4'd8,  16'h0010, "alu_shr");
        alu(8'h05, 8'h03, 4'd9,  16'h0001, "alu_gt_true");
        alu(8'h03, 8'h05, 4'd9,  16'h0000, "alu_gt_false");
        alu(8'h07, 8'h07, 4'd10, 16'h0001, "alu_eq");
        alu(8'hFF, 8'hFF, 4'd2,  16'hFE01, "alu_mul_max");
        alu(8'h12, 8'h34, 4'd12, 16'h0000, "alu_reserved");

        // Upper address bits ignored; reads ignore ConfigDiv.
        cmd(1'b1, 1'b0, 8'h1F, 32'hDEAD_BEEF, 8'h00, 8'h00, 4'h0);
        push(K_READ, {31'h0, 1'b1, 32'hDEAD_BEEF}, "read_addr15_cfg1");
        cmd(1'b0, 1'b1, 8'h0F, 32'h0, 8'h00, 8'h00, 4'h0);

        // Divider off: ClkOut settles at 0 and stays there.
        cmd(1'b1, 1'b1, 8'h01, 32'h0, 8'h00, 8'h00, 4'h0);
        step();
        for (int i = 0; i < 4; i++) idle_clk(1'b0, "clkout_div0_low");
        push(K_READ, {31'h0, 1'b1, 32'h0000_00A5}, "div_write_keeps_mem");
        cmd(1'b0, 1'b0, 8'h01, 32'h0, 8'h00, 8'h00, 4'h0);

        // Divider = 2: period of 4 clocks starting from the low level.
        push(K_CLK, 64'h0, "clkout_div2_write_edge");
        cmd(1'b1, 1'b1, 8'h00, 32'h2, 8'h00, 8'h00, 4'h0);
        idle_clk(1'b0, "clkout_div2_e1");
        idle_clk(1'b1, "clkout_div2_e2");
        idle_clk(1'b1, "clkout_div2_e3");
        idle_clk(1'b0, "clkout_div2_e4");
        idle_clk(1'b0, "clkout_div2_e5");
        idle_clk(1'b1, "clkout_div2_e6");
        idle_clk(1'b1, "clkout_div2_e7");
        idle_clk(1'b0, "clkout_div2_e8");

        // Reset mid-command aborts it and relocks.
        bus.ValidCmd  = 1'b1;
        bus.RW        = 1'b1;
        bus.ConfigDiv = 1'b0;
        bus.Addr      = 8'h03;
        bus.Din       = 32'h33;
        Reset         = 1'b0;
        push_now(K_RST, RST_EXP, "midop_reset_state");
        step();
        Reset         = 1'b1;
        bus.ValidCmd  = 1'b0;
        bus.InputKey  = 1'b1;

        push(K_ALU, {47'h0, 1'b1, 16'h0000}, "relocked_alu_hold");
        push(K_UNLK, 64'h0, "relocked_unl");
        cmd(1'b1, 1'b0, 8'h02, 32'h77, 8'h01, 8'h01, 4'h0);

        // Key 0,1,1,0,1,0,1.
        key(1'b0, 1'b0, "key_b1");
        key(1'b1, 1'b0, "key_b2");
        key(1'b1, 1'b0, "key_b3_broken");
        key(1'b0, 1'b0, "key_b4");
        key(1'b1, 1'b0, "key_b5");
        key(1'b0, 1'b0, "key_b6");
        key(1'b1, 1'b1, "key_b7_open");

        push(K_READ, {31'h0, 1'b1, 32'h0}, "read_addr2_locked_write");
        cmd(1'b0, 1'b0, 8'h02, 32'h0, 8'h00, 8'h00, 4'h0);
        push(K_READ, {31'h0, 1'b1, 32'h0}, "read_addr3_aborted");
        cmd(1'b0, 1'b0, 8'h03, 32'h0, 8'h00, 8'h00, 4'h0);
        push(K_READ, {31'h0, 1'b1, 32'h0}, "read_addr1_cleared");
        cmd(1'b0, 1'b0, 8'h01, 32'h0, 8'h00, 8'h00, 4'h0);
        push(K_NORD, 64'h0, "rdvalid_one_pulse_c");
        step();
        repeat (3) step();

        total_cnt++;
        if (sb.size() == 0)
            pass_cnt++;
        else
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
